// File: rtl/move_scheduler_if.sv
// Move descriptor write port between the SPI word handler and the move scheduler.
//   wr_valid     : descriptor present on the wr_* buses
//   wr_ready     : scheduler can accept a descriptor this cycle
//   wr_dir       : direction bit for the move
//   wr_duration  : move length in DDA ticks
//   wr_increment : signed initial per-tick increment
//   wr_incinc    : signed per-tick change of increment
interface move_scheduler_if #(
   parameter int unsigned DUR_W = 64,
   parameter int unsigned INC_W = 64
);
   logic             wr_valid;
   logic             wr_ready;
   logic             wr_dir;
   logic [DUR_W-1:0] wr_duration;
   logic [INC_W-1:0] wr_increment;
   logic [INC_W-1:0] wr_incinc;

   modport master (
      output wr_valid,
      output wr_dir,
      output wr_duration,
      output wr_increment,
      output wr_incinc,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_dir,
      input  wr_duration,
      input  wr_increment,
      input  wr_incinc,
      output wr_ready
   );
endinterface

// File: rtl/move_scheduler.sv
// Buffered coordinated-move sequencer. Move descriptors arrive on a valid/ready port, are
// queued in a 2^BUFFER_BITS ring buffer and executed back-to-back by a clock-divided DDA that
// emits one-cycle step pulses and a direction level for the stepper driver.
//   clk           : system clock
//   resetn        : asynchronous active-low reset
//   wr            : descriptor write port (slave side)
//   clock_divisor : clk cycles per DDA tick, 0 behaves as 1, sampled live
//   abort         : level-sensitive flush/stop, priority over everything
//   step          : one-cycle step pulse
//   dir           : direction of the current/last move
//   busy          : a move is being loaded or run
//   buffer_empty  : no queued descriptors
//   buffer_full   : all buffer slots occupied
//   moves_done    : completed-move counter, wraps
module move_scheduler #(
   parameter int unsigned BUFFER_BITS = 2,
   parameter int unsigned DUR_W       = 64,
   parameter int unsigned INC_W       = 64,
   parameter int unsigned DIV_W       = 24
) (
   input  logic             clk,
   input  logic             resetn,
   move_scheduler_if.slave  wr,
   input  logic [DIV_W-1:0] clock_divisor,
   input  logic             abort,
   output logic             step,
   output logic             dir,
   output logic             busy,
   output logic             buffer_empty,
   output logic             buffer_full,
   output logic [7:0]       moves_done
);

   localparam int unsigned Depth = 2 ** BUFFER_BITS;
   localparam int unsigned PtrW  = BUFFER_BITS + 1;
   localparam int unsigned DescW = 1 + DUR_W + 2 * INC_W;
   // One full step worth of accumulator, subtracted whenever a step is emitted.
   localparam logic [INC_W-1:0] StepK = INC_W'(64'sh7fff_ffff_ffff_ff9b);

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

   state_e           state_q, state_d;
   logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [DUR_W-1:0] tickdown_q, tickdown_d;
   logic [INC_W-1:0] acc_q, acc_d;
   logic [INC_W-1:0] inc_q, inc_d;
   logic [INC_W-1:0] incinc_q, incinc_d;
   logic [DIV_W-1:0] clkaccum_q, clkaccum_d;
   logic             step_q, step_d;
   logic             dir_q, dir_d;
   logic [7:0]       moves_done_q, moves_done_d;

   logic [DescW-1:0] fifo_mem [Depth];
   logic [DescW-1:0] head;
   logic             head_dir;
   logic [DUR_W-1:0] head_dur;
   logic [INC_W-1:0] head_inc, head_incinc;
   logic             push;
   logic [DIV_W-1:0] div_m1;
   logic [INC_W-1:0] acc_sum;
   logic             acc_pos;

   // Extra pointer MSB distinguishes full from empty when the slot indices match.
   assign buffer_empty = (wptr_q == rptr_q);
   assign buffer_full  = (wptr_q[BUFFER_BITS] != rptr_q[BUFFER_BITS]) &&
                         (wptr_q[BUFFER_BITS-1:0] == rptr_q[BUFFER_BITS-1:0]);
   assign wr.wr_ready  = !buffer_full && !abort;
   assign push         = wr.wr_valid && wr.wr_ready;

   assign head        = fifo_mem[rptr_q[BUFFER_BITS-1:0]];
   assign head_dir    = head[DescW-1];
   assign head_dur    = head[DescW-2 -: DUR_W];
   assign head_inc    = head[2*INC_W-1 -: INC_W];
   assign head_incinc = head[INC_W-1:0];

   assign div_m1  = (clock_divisor == '0) ? '0 : clock_divisor - DIV_W'(1);
   assign acc_sum = acc_q + inc_q;
   // Signed acc_sum > 0: sign bit clear and not zero.
   assign acc_pos = !acc_sum[INC_W-1] && (acc_sum != '0);

   assign step       = step_q;
   assign dir        = dir_q;
   assign busy       = (state_q != StIdle);
   assign moves_done = moves_done_q;

   always_comb begin
      state_d      = state_q;
      wptr_d       = push ? wptr_q + PtrW'(1) : wptr_q;
      rptr_d       = rptr_q;
      dir_d        = dir_q;
      tickdown_d   = tickdown_q;
      acc_d        = acc_q;
      inc_d        = inc_q;
      incinc_d     = incinc_q;
      clkaccum_d   = clkaccum_q;
      step_d       = 1'b0;
      moves_done_d = moves_done_q;

      if (abort) begin
         // push is already blocked by wr_ready, so flushing means rptr catches up.
         rptr_d     = wptr_q;
         state_d    = StIdle;
         acc_d      = '0;
         clkaccum_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!buffer_empty) state_d = StLoad;
            end
            StLoad: begin
               rptr_d     = rptr_q + PtrW'(1);
               dir_d      = head_dir;
               tickdown_d = head_dur;
               inc_d      = head_inc;
               incinc_d   = head_incinc;
               clkaccum_d = '0;
               if (head_dur == '0) begin
                  moves_done_d = moves_done_q + 8'd1;
                  state_d      = StIdle;
               end else begin
                  state_d = StRun;
               end
            end
            StRun: begin
               clkaccum_d = clkaccum_q + DIV_W'(1);
               if (clkaccum_q == div_m1) begin
                  clkaccum_d = '0;
                  step_d     = acc_pos;
                  acc_d      = acc_pos ? acc_sum - StepK : acc_sum;
                  inc_d      = inc_q + incinc_q;
                  tickdown_d = tickdown_q - DUR_W'(1);
                  if (tickdown_q == DUR_W'(1)) begin
                     moves_done_d = moves_done_q + 8'd1;
                     // No pop happens in RUN, so any pending or same-cycle push means work.
                     state_d      = (wptr_d != rptr_q) ? StLoad : StIdle;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= StIdle;
         wptr_q       <= '0;
         rptr_q       <= '0;
         dir_q        <= 1'b0;
         tickdown_q   <= '0;
         acc_q        <= '0;
         inc_q        <= '0;
         incinc_q     <= '0;
         clkaccum_q   <= '0;
         step_q       <= 1'b0;
         moves_done_q <= '0;
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         dir_q        <= dir_d;
         tickdown_q   <= tickdown_d;
         acc_q        <= acc_d;
         inc_q        <= inc_d;
         incinc_q     <= incinc_d;
         clkaccum_q   <= clkaccum_d;
         step_q       <= step_d;
         moves_done_q <= moves_done_d;
      end
   end

   // Descriptor storage needs no reset: slots are only read after being written.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wptr_q[BUFFER_BITS-1:0]] <= {wr.wr_dir, wr.wr_duration, wr.wr_increment,
                                               wr.wr_incinc};
      end
   end

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: a queue-based behavioural model is compared with
// the DUT on every falling clock edge, and directed scenarios pin the model with literals.
module tb_move_scheduler;
   localparam int unsigned BB    = 2;
   localparam int unsigned DUR_W = 64;
   localparam int unsigned INC_W = 64;
   localparam int unsigned DIV_W = 24;
   localparam logic signed [63:0] KS = 64'sh7fffffffffffff9b;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             abort = 1'b0;
   logic [DIV_W-1:0] clock_divisor = DIV_W'(1);
   logic             step, dir, busy, buffer_empty, buffer_full;
   logic [7:0]       moves_done;

   move_scheduler_if #(.DUR_W(DUR_W), .INC_W(INC_W)) wr_if ();

   move_scheduler #(
      .BUFFER_BITS (BB),
      .DUR_W       (DUR_W),
      .INC_W       (INC_W),
      .DIV_W       (DIV_W)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .wr            (wr_if),
      .clock_divisor (clock_divisor),
      .abort         (abort),
      .step          (step),
      .dir           (dir),
      .busy          (busy),
      .buffer_empty  (buffer_empty),
      .buffer_full   (buffer_full),
      .moves_done    (moves_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        d;
      logic [63:0] dur;
      logic [63:0] inc;
      logic [63:0] incinc;
   } mv_t;

   mv_t                mq[$];
   int                 m_mode;      // 0 waiting, 1 taking a move, 2 executing ticks
   logic               m_step, m_dir;
   logic [7:0]         m_done;
   logic signed [63:0] m_acc, m_inc, m_incinc;
   longint unsigned    m_ticks;
   int                 m_wait;
   int                 m_steps;

   initial forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
         mq.delete();
         m_mode = 0; m_step = 0; m_dir = 0; m_done = 0;
         m_acc = 0; m_inc = 0; m_incinc = 0; m_ticks = 0; m_wait = 0;
      end else begin : model_edge
         int                 div_eff;
         bit                 do_push;
         mv_t                mv;
         logic signed [63:0] nxt;
         div_eff = (clock_divisor == 0) ? 1 : int'(clock_divisor);
         do_push = wr_if.wr_valid && (mq.size() < 4) && !abort;
         m_step  = 0;
         if (abort) begin
            mq.delete();
            m_mode = 0;
            m_acc  = 0;
         end else begin
            case (m_mode)
               0: if (mq.size() > 0) m_mode = 1;
               1: begin
                  mv        = mq.pop_front();
                  m_dir     = mv.d;
                  m_ticks   = mv.dur;
                  m_inc     = mv.inc;
                  m_incinc  = mv.incinc;
                  m_wait    = div_eff;
                  if (mv.dur == 0) begin
                     m_done++;
                     m_mode = 0;
                  end else begin
                     m_mode = 2;
                  end
               end
               default: begin
                  m_wait--;
                  if (m_wait == 0) begin
                     m_wait = div_eff;
                     nxt    = m_acc + m_inc;
                     if (nxt > 0) begin
                        m_step = 1;
                        m_acc  = nxt - KS;
                        m_steps++;
                     end else begin
                        m_acc = nxt;
                     end
                     m_inc = m_inc + m_incinc;
                     m_ticks--;
                     if (m_ticks == 0) begin
                        m_done++;
                        m_mode = (mq.size() > 0 || do_push) ? 1 : 0;
                     end
                  end
               end
            endcase
            if (do_push) mq.push_back({wr_if.wr_dir, wr_if.wr_duration, wr_if.wr_increment,
                                       wr_if.wr_incinc});
         end
      end
   end

   // ---------------- compare process ----------------
   int         dut_steps;
   int         busy_cycles;
   longint     step_times[$];
   logic       done_dirs[$];
   logic [7:0] prev_done = 0;

   initial forever begin
      @(negedge clk);
      if (!resetn) begin
         prev_done = 0;
      end else begin
         chk("step", step, m_step);
         chk("dir", dir, m_dir);
         chk("busy", busy, m_mode != 0);
         chk("buffer_empty", buffer_empty, mq.size() == 0);
         chk("buffer_full", buffer_full, mq.size() == 4);
         chk("wr_ready", wr_if.wr_ready, (mq.size() < 4) && !abort);
         chk("moves_done", moves_done, m_done);
         if (step) begin
            dut_steps++;
            step_times.push_back(longint'($time));
         end
         if (busy) busy_cycles++;
         if (moves_done == prev_done + 8'd1) done_dirs.push_back(dir);
         prev_done = moves_done;
      end
   end

   // ---------------- stimulus helpers (all input changes happen 2 units after posedge) ---
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      dut_steps = 0; m_steps = 0; busy_cycles = 0;
      step_times.delete();
      done_dirs.delete();
   endtask

   task automatic push_move(input logic d, input logic [63:0] dur, input logic [63:0] inc,
                            input logic [63:0] incinc, output int waited);
      bit ok;
      ok = 0;
      waited = 0;
      wr_if.wr_valid     = 1'b1;
      wr_if.wr_dir       = d;
      wr_if.wr_duration  = dur;
      wr_if.wr_increment = inc;
      wr_if.wr_incinc    = incinc;
      while (!ok && waited < 5000) begin
         @(negedge clk);
         ok = wr_if.wr_ready;
         tick();
         if (!ok) waited++;
      end
      wr_if.wr_valid = 1'b0;
      if (!ok) fail_now("push accept");
   endtask

   task automatic wait_idle(input int budget);
      bit idle;
      idle = 0;
      for (int i = 0; i < budget && !idle; i++) begin
         @(negedge clk);
         if (!busy && buffer_empty) idle = 1;
      end
      if (!idle) fail_now("wait idle");
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int  w;
      bit  seen;
      logic [63:0] k;
      k = 64'h7fffffffffffff9b;
      wr_if.wr_valid = 0; wr_if.wr_dir = 0; wr_if.wr_duration = 0;
      wr_if.wr_increment = 0; wr_if.wr_incinc = 0;
      dut_steps = 0; m_steps = 0; busy_cycles = 0;
      repeat (2) @(posedge clk);
      #2;
      // Reset values
      chk("rst step", step, 0);
      chk("rst dir", dir, 0);
      chk("rst busy", busy, 0);
      chk("rst empty", buffer_empty, 1);
      chk("rst full", buffer_full, 0);
      chk("rst wr_ready", wr_if.wr_ready, 1);
      chk("rst moves_done", moves_done, 0);
      do_reset();

      // 1: three steps, four cycles apart
      clock_divisor = 4;
      push_move(1'b1, 64'd3, k, 64'd0, w);
      wait_idle(200);
      chk("t1 steps", dut_steps, 3);
      chk("t1 model steps", m_steps, 3);
      if (step_times.size() == 3) begin
         chk("t1 gap0", step_times[1] - step_times[0], 40);
         chk("t1 gap1", step_times[2] - step_times[1], 40);
      end else begin
         chk("t1 step count", step_times.size(), 3);
      end
      chk("t1 dir", dir, 1);
      chk("t1 done", moves_done, 1);
      chk("t1 busy", busy, 0);
      chk("t1 empty", buffer_empty, 1);

      // 2: zero increment, no steps, busy for LOAD + 5*4 cycles
      do_reset();
      clock_divisor = 4;
      push_move(1'b0, 64'd5, 64'd0, 64'd0, w);
      wait_idle(200);
      chk("t2 steps", dut_steps, 0);
      chk("t2 busy cycles", busy_cycles, 21);
      chk("t2 done", moves_done, 1);

      // 3: fill the buffer behind a slow move; the sixth push must be held
      do_reset();
      clock_divisor = 1000;
      for (int i = 0; i < 5; i++) push_move(logic'(i % 2 == 0), 64'd1, k, 64'd0, w);
      @(negedge clk);
      chk("t3 full", buffer_full, 1);
      chk("t3 ready low", wr_if.wr_ready, 0);
      tick();
      push_move(1'b0, 64'd1, k, 64'd0, w);
      chk("t3 push6 held", w > 900, 1);
      wait_idle(10000);
      chk("t3 done", moves_done, 6);
      chk("t3 model done", m_done, 6);
      chk("t3 dir count", done_dirs.size(), 6);
      if (done_dirs.size() == 6) begin
         for (int i = 0; i < 6; i++) chk("t3 dir seq", done_dirs[i], (i % 2 == 0) ? 1 : 0);
      end

      // 4: zero-length move then a two-tick move
      do_reset();
      clock_divisor = 3;
      push_move(1'b1, 64'd0, k, 64'd0, w);
      push_move(1'b0, 64'd2, k, 64'd0, w);
      wait_idle(200);
      chk("t4 steps", dut_steps, 2);
      chk("t4 model steps", m_steps, 2);
      chk("t4 done", moves_done, 2);
      chk("t4 dir", dir, 0);

      // 5: abort mid-run with two moves queued and a push presented
      do_reset();
      clock_divisor = 4;
      for (int i = 0; i < 3; i++) push_move(1'b1, 64'd5, k, 64'd0, w);
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = step;
      end
      if (!seen) fail_now("t5 first step");
      tick();
      chk("t5 queued before abort", buffer_empty, 0);
      abort = 1'b1;
      wr_if.wr_valid = 1'b1; wr_if.wr_dir = 1'b0; wr_if.wr_duration = 64'd2;
      tick();
      @(negedge clk);
      chk("t5 step", step, 0);
      chk("t5 busy", busy, 0);
      chk("t5 empty", buffer_empty, 1);
      chk("t5 done", moves_done, 0);
      chk("t5 ready", wr_if.wr_ready, 0);
      tick();
      abort = 1'b0;
      wr_if.wr_valid = 1'b0;
      repeat (3) tick();
      chk("t5 push dropped", buffer_empty, 1);
      chk("t5 still idle", busy, 0);

      // 6: asynchronous reset mid-move, then accumulator must start from zero
      do_reset();
      clock_divisor = 4;
      push_move(1'b1, 64'd10, -64'sd5, 64'd0, w);
      repeat (12) tick();
      #1;
      resetn = 1'b0;
      #1;
      chk("t6 step", step, 0);
      chk("t6 dir", dir, 0);
      chk("t6 busy", busy, 0);
      chk("t6 empty", buffer_empty, 1);
      chk("t6 full", buffer_full, 0);
      chk("t6 ready", wr_if.wr_ready, 1);
      chk("t6 done", moves_done, 0);
      tick();
      do_reset();
      push_move(1'b0, 64'd1, 64'd1, 64'd0, w);
      wait_idle(200);
      chk("t6 resume steps", dut_steps, 1);
      chk("t6 resume done", moves_done, 1);

      // Randomized traffic, divisor fixed per batch (0 behaves as 1)
      do_reset();
      for (int b = 0; b < 4; b++) begin
         clock_divisor = DIV_W'(b * 2);
         for (int c = 0; c < 1200; c++) begin
            wr_if.wr_valid    = ($urandom % 3) != 0;
            wr_if.wr_dir      = 1'($urandom);
            wr_if.wr_duration = 64'($urandom_range(0, 4));
            case ($urandom % 4)
               0:       wr_if.wr_increment = k;
               1:       wr_if.wr_increment = {$urandom, $urandom};
               2:       wr_if.wr_increment = 64'($urandom_range(0, 1000)) - 64'd500;
               default: wr_if.wr_increment = k >> 1;
            endcase
            wr_if.wr_incinc = ($urandom % 2) ? 64'd0 : {$urandom, $urandom};
            abort = ($urandom % 60) == 0;
            tick();
         end
         abort = 1'b0;
         wr_if.wr_valid = 1'b0;
         wait_idle(5000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
